// File: rtl/alu_arbiter_1210606.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Latency: 2 edges from accepting edge to done; min issue interval 3 cycles.
// Backpressure: result held with done=1 until ack; requests ignored while busy.
module alu_arbiter_1210606 #(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0,
   input  logic                req1,
   input  logic signed [N-1:0] x0,
   input  logic signed [N-1:0] y0,
   input  logic signed [N-1:0] x1,
   input  logic signed [N-1:0] y1,
   input  logic [2:0]          op0,
   input  logic [2:0]          op1,
   output logic                gnt0,
   output logic                gnt1,
   output logic signed [N-1:0] alu_x,
   output logic signed [N-1:0] alu_y,
   output logic [2:0]          alu_c,
   input  logic signed [N+1:0] alu_o,
   output logic signed [N+1:0] result,
   output logic                done,
   output logic                done_id,
   input  logic                ack,
   output logic                busy,
   output logic [7:0]          op_cnt
);

   typedef enum logic [1:0] {IDLE, EXEC, WAIT_ACK} state_t;

   state_t state, state_nxt;
   logic   prio;     // requester that wins a tie (the one not granted last)
   logic   owner;    // requester whose operation is in flight
   logic   win;      // arbitration winner for the current cycle
   logic   accept;   // IDLE edge that takes a request
   logic   capture;  // EXEC edge that samples the ALU result
   logic   finish;   // WAIT_ACK edge where the owner acknowledges

   // Round-robin pick: a lone request wins, a tie goes to the priority holder
   assign win = (req0 & req1) ? prio : req1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      finish    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            busy      = 1'b1;
            capture   = 1'b1;
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            busy = 1'b1;
            done = 1'b1;
            if (ack) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant pulse, operand latch, result capture and completion counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         alu_x   <= '0;
         alu_y   <= '0;
         alu_c   <= 3'b000;
         owner   <= 1'b0;
         prio    <= 1'b0;
         result  <= '0;
         done_id <= 1'b0;
         op_cnt  <= 8'd0;
      end else begin
         gnt0 <= accept & ~win;
         gnt1 <= accept & win;
         if (accept) begin
            alu_x <= win ? x1  : x0;
            alu_y <= win ? y1  : y0;
            alu_c <= win ? op1 : op0;
            owner <= win;
            prio  <= ~win;
         end
         if (capture) begin
            result  <= alu_o;
            done_id <= owner;
         end
         if (finish) begin
            op_cnt <= op_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter_1210606.sv
// Randomized and directed bench for alu_arbiter_1210606 with a transaction-level model.
// Latency: checks every cycle on the falling edge; model advances on rising edges.
// Backpressure: ack is driven randomly or held low to stall the result.
module tb_alu_arbiter_1210606;
   localparam int N = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                req0, req1, ack;
   logic signed [N-1:0] x0, y0, x1, y1;
   logic [2:0]          op0, op1;
   logic                gnt0, gnt1, done, done_id, busy;
   logic signed [N-1:0] alu_x, alu_y;
   logic [2:0]          alu_c;
   logic signed [N+1:0] alu_o, result;
   logic [7:0]          op_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // External ALU behaviour; op 7 returns a fixed marker value
   function automatic logic signed [N+1:0] alu_f(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b,
                                                 input logic [2:0] c);
      logic signed [N+1:0] ae, be;
      ae = a;
      be = b;
      case (c)
         3'd0:    return ae + be;
         3'd1:    return ae - be;
         3'd2:    return ae & be;
         3'd3:    return ae | be;
         3'd4:    return ae ^ be;
         3'd5:    return -ae;
         3'd6:    return be <<< 1;
         default: return 6'sh2A;
      endcase
   endfunction

   assign alu_o = alu_f(alu_x, alu_y, alu_c);

   always #5 clk = ~clk;

   alu_arbiter_1210606 #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .op0(op0), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1),
      .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c),
      .alu_o(alu_o),
      .result(result), .done(done), .done_id(done_id),
      .ack(ack), .busy(busy), .op_cnt(op_cnt)
   );

   // Transaction model: an operation is either absent or some edges old
   int                  m_age;    // 0 none, 1 issued last edge, 2 result ready
   bit                  m_last;   // requester granted most recently
   bit                  m_owner, m_did, m_g0, m_g1;
   logic signed [N-1:0] m_x, m_y;
   logic [2:0]          m_c;
   logic signed [N+1:0] m_res;
   int                  m_cnt;
   int                  gq[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_age = 0; m_last = 1'b1; m_owner = 1'b0; m_did = 1'b0;
      m_g0 = 1'b0; m_g1 = 1'b0; m_x = '0; m_y = '0; m_c = '0;
      m_res = '0; m_cnt = 0;
   endtask

   task automatic model_edge();
      bit w;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (m_age == 0) begin
         if (req0 || req1) begin
            w = (req0 && req1) ? !m_last : req1;
            m_last = w; m_owner = w;
            m_x = w ? x1 : x0; m_y = w ? y1 : y0; m_c = w ? op1 : op0;
            m_g0 = !w; m_g1 = w;
            m_age = 1;
         end
      end else if (m_age == 1) begin
         m_res = alu_f(m_x, m_y, m_c);
         m_did = m_owner;
         m_age = 2;
      end else if (ack) begin
         m_cnt = (m_cnt + 1) % 256;
         m_age = 0;
      end
   endtask

   task automatic check_all();
      check_val("gnt0", gnt0, m_g0);
      check_val("gnt1", gnt1, m_g1);
      check_val("gnt_excl", gnt0 & gnt1, 1'b0);
      check_val("busy", busy, m_age != 0);
      check_val("done", done, m_age == 2);
      check_val("done_id", done_id, m_did);
      check_val("result", result, m_res);
      check_val("alu_x", alu_x, m_x);
      check_val("alu_y", alu_y, m_y);
      check_val("alu_c", alu_c, m_c);
      check_val("op_cnt", op_cnt, m_cnt[7:0]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_gnt0", gnt0, 1'b0);
      check_val("rst_gnt1", gnt1, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_done_id", done_id, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_alu_x", alu_x, 0);
      check_val("rst_alu_y", alu_y, 0);
      check_val("rst_alu_c", alu_c, 0);
      check_val("rst_result", result, 0);
      check_val("rst_op_cnt", op_cnt, 0);
      model_reset();
      req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive_rand();
      req0 = ($urandom_range(0, 2) == 0) && !gnt0;
      req1 = ($urandom_range(0, 2) == 0) && !gnt1;
      ack  = ($urandom_range(0, 1) == 0);
      x0 = N'($urandom); y0 = N'($urandom); op0 = 3'($urandom);
      x1 = N'($urandom); y1 = N'($urandom); op1 = 3'($urandom);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; op0 = '0; op1 = '0;
      do_reset();

      // Single operation, then operand changes after accept must not leak
      x0 = 4'sd3; y0 = -4'sd2; op0 = 3'd7; req0 = 1'b1;
      step();
      check_val("single_gnt0", gnt0, 1'b1);
      check_val("single_alu_c", alu_c, 3'd7);
      req0 = 1'b0; x0 = 4'sd5; op0 = 3'd2;
      step();
      check_val("single_done", done, 1'b1);
      check_val("single_done_id", done_id, 1'b0);
      check_val("single_result", result, 6'sh2A);
      check_val("hold_alu_x", alu_x, 4'sd3);
      check_val("hold_alu_c", alu_c, 3'd7);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // Ack stall with a competing request waiting
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      step();
      req1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_val("stall_done", done, 1'b1);
         check_val("stall_busy", busy, 1'b1);
         check_val("stall_gnt1", gnt1, 1'b0);
      end
      ack = 1'b1;
      step();
      check_val("ack_edge_gnt1", gnt1, 1'b0);
      ack = 1'b0;
      step();
      check_val("after_ack_gnt1", gnt1, 1'b1);
      req1 = 1'b0;
      step();
      ack = 1'b1;
      step();

      // Contention from reset: grants alternate starting with requester 0
      do_reset();
      gq.delete();
      req0 = 1'b1; req1 = 1'b1; ack = 1'b1;
      repeat (12) step();
      check_val("rr_count", gq.size(), 4);
      for (int i = 0; i < gq.size(); i++) check_val("rr_order", gq[i], i % 2);

      // Reset while executing discards the operation
      do_reset();
      req0 = 1'b1; ack = 1'b0;
      step();
      req0 = 1'b0;
      do_reset();
      ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_val("post_rst_done", done, 1'b0);
      end

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         drive_rand();
         step();
      end

      // Counter wrap after 256 completions
      do_reset();
      req0 = 1'b1; req1 = 1'b0; ack = 1'b1;
      for (int i = 0; i < 765; i++) begin
         x0 = N'($urandom); op0 = 3'($urandom);
         step();
      end
      check_val("cnt_255", op_cnt, 8'd255);
      repeat (3) step();
      check_val("cnt_wrap", op_cnt, 8'd0);
      repeat (6) step();
      check_val("cnt_after_wrap", op_cnt, 8'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter_1210606.md
ALU_ARBITER_1210606 -- requirements
Module: alu_arbiter_1210606

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand width in bits; result width is N+2.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  operation request from requester 0 and requester 1.
REQ-005 SHALL have ports x0, y0, x1, y1  input  N each, signed  operands of each requester.
REQ-006 SHALL have ports op0, op1  input  3 each  ALU operation select of each requester.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulse to the winning requester.
REQ-008 SHALL have ports alu_x, alu_y  output  N each, signed; alu_c  output  3  registered operands and select driven to the external ALU.
REQ-009 SHALL have port alu_o  input  N+2, signed  combinational result returned by the ALU.
REQ-010 SHALL have ports result  output  N+2, signed; done  output  1; done_id  output  1  captured result, result-valid, owner (0/1).
REQ-011 SHALL have port ack  input  1  result accepted by the owner while done=1.
REQ-012 SHALL have ports busy  output  1; op_cnt  output  8  FSM not in IDLE; completed-operation counter.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, WAIT_ACK; busy=1 in EXEC and WAIT_ACK.
REQ-014 IDLE: on edge with req0|req1 high, SHALL select a winner, latch its x/y/op into alu_x/alu_y/alu_c, record owner, assert that gnt for exactly the following cycle, go EXEC; no request -> stay IDLE, alu_* unchanged.
REQ-015 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted most recently wins; priority pointer updates on every grant.
REQ-016 EXEC: SHALL hold alu_* constant, capture alu_o into result on the next edge, set done=1, done_id=owner, go WAIT_ACK.
REQ-017 WAIT_ACK: done and result SHALL hold; on edge with ack=1, done clears, op_cnt increments, FSM goes IDLE.
REQ-018 Request latency: SHALL be exactly 2 edges from accepting edge to done asserted; minimum issue interval SHALL be 3 cycles with ack tied high.
REQ-019 Requests and ack SHALL be ignored outside IDLE and WAIT_ACK respectively; a req held high through gnt SHALL be re-arbitrated only after return to IDLE.
REQ-020 Requester contract: SHALL deassert req in the cycle gnt is observed; operands need only be valid on the accepting edge.
REQ-021 gnt0 and gnt1 SHALL never be high together; done SHALL never be high in IDLE or EXEC.
REQ-022 result SHALL be alu_o bit-exact, no re-sign-extension; result SHALL retain last value after done clears.
REQ-023 op_cnt SHALL wrap 255 -> 0 without side effects.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, gnt0=gnt1=0, done=0, done_id=0, busy=0, alu_x=alu_y=0, alu_c=3'b000, result=0, op_cnt=0, priority to requester 0.
REQ-025 Reset asserted in EXEC or WAIT_ACK SHALL discard the in-flight operation; no done or op_cnt increment SHALL follow.
REQ-026 After rst_n rises, first accepting edge SHALL be the first rising clk edge with rst_n high.

Verification
REQ-027 Single op: req0=1, x0=4'sd3, y0=-4'sd2, op0=3'd7, ALU model alu_o=6'sh2A -> gnt0 pulse, alu_c=7, done=1 with done_id=0, result=6'sh2A two edges after accept.
REQ-028 Contention: req0=req1=1 continuously, ack=1 -> grants alternate 0,1,0,1; first grant to requester 0 after reset.
REQ-029 Ack stall: hold ack=0 for 10 cycles -> done and result stable, busy=1, new req1 not granted until one edge after ack=1.
REQ-030 Reset mid-op: drop rst_n during EXEC -> all outputs at REQ-024 values asynchronously; no done after release.
REQ-031 Counter wrap: 256 completed ops -> op_cnt returns to 0, FSM behaviour unchanged.
REQ-032 Operand hold: change x0/op0 in cycle after accept -> alu_x/alu_c keep latched values until next grant.
